// File: rtl/ca_code_acq_pkg.sv
// Shared definitions for the C/A code acquisition engine: code constants,
// acquisition FSM states and the G2 tap-pair table for PRN 1..32.
package gnss_ca_pkg;

   localparam int CA_LEN  = 1023;
   localparam int PRN_MIN = 1;
   localparam int PRN_MAX = 32;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DWELL,
      SLIP,
      DONE
   } acq_state_t;

   // Returns {tap_a, tap_b}, G2 stage numbers 1..10 XORed to form the PRN chip
   function automatic logic [7:0] g2_taps(input logic [5:0] prn);
      logic [7:0] t;
      case (prn)
         6'd1:    t = {4'd2, 4'd6};
         6'd2:    t = {4'd3, 4'd7};
         6'd3:    t = {4'd4, 4'd8};
         6'd4:    t = {4'd5, 4'd9};
         6'd5:    t = {4'd1, 4'd9};
         6'd6:    t = {4'd2, 4'd10};
         6'd7:    t = {4'd1, 4'd8};
         6'd8:    t = {4'd2, 4'd9};
         6'd9:    t = {4'd3, 4'd10};
         6'd10:   t = {4'd2, 4'd3};
         6'd11:   t = {4'd3, 4'd4};
         6'd12:   t = {4'd5, 4'd6};
         6'd13:   t = {4'd6, 4'd7};
         6'd14:   t = {4'd7, 4'd8};
         6'd15:   t = {4'd8, 4'd9};
         6'd16:   t = {4'd9, 4'd10};
         6'd17:   t = {4'd1, 4'd4};
         6'd18:   t = {4'd2, 4'd5};
         6'd19:   t = {4'd3, 4'd6};
         6'd20:   t = {4'd4, 4'd7};
         6'd21:   t = {4'd5, 4'd8};
         6'd22:   t = {4'd6, 4'd9};
         6'd23:   t = {4'd1, 4'd3};
         6'd24:   t = {4'd4, 4'd6};
         6'd25:   t = {4'd5, 4'd7};
         6'd26:   t = {4'd6, 4'd8};
         6'd27:   t = {4'd7, 4'd9};
         6'd28:   t = {4'd8, 4'd10};
         6'd29:   t = {4'd1, 4'd6};
         6'd30:   t = {4'd2, 4'd7};
         6'd31:   t = {4'd3, 4'd8};
         6'd32:   t = {4'd4, 4'd9};
         default: t = {4'd2, 4'd6};
      endcase
      return t;
   endfunction

   function automatic logic prn_ok(input logic [5:0] prn);
      return (prn >= 6'(PRN_MIN)) && (prn <= 6'(PRN_MAX));
   endfunction

endpackage

// File: rtl/ca_code_acq_if.sv
// Control, sample and result bundle between the front-end/tracking side
// (master) and the acquisition engine (slave).
interface ca_code_acq_if #(
   parameter int ACC_W   = 11,
   parameter int PHASE_W = 10
);
   logic                      start;
   logic [5:0]                prn_select;
   logic                      sample_in;
   logic                      sample_valid;
   logic                      busy;
   logic                      done;
   logic                      lock;
   logic                      err;
   logic [PHASE_W-1:0]        best_phase;
   logic signed [ACC_W-1:0]   best_corr;

   modport master (
      output start, prn_select, sample_in, sample_valid,
      input  busy, done, lock, err, best_phase, best_corr
   );

   modport slave (
      input  start, prn_select, sample_in, sample_valid,
      output busy, done, lock, err, best_phase, best_corr
   );
endinterface

// File: rtl/ca_code_acq_step.sv
// Local C/A replica: G1/G2 LFSR pair, chip taken combinationally from the
// current register state; load returns both registers to all-ones.
module ca_code_step
   import gnss_ca_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       step,
   input  logic [5:0] prn,
   output logic       chip
);
   // bit n holds LFSR stage n+1; stage 10 is the output end
   logic [9:0] g1_reg, g2_reg;
   logic [9:0] g1_next, g2_next;
   logic [9:0] sel_a, sel_b;
   logic [7:0] taps;

   assign taps    = g2_taps(prn);
   assign g1_next = {g1_reg[8:0], g1_reg[2] ^ g1_reg[9]};
   assign g2_next = {g2_reg[8:0], g2_reg[1] ^ g2_reg[2] ^ g2_reg[5] ^
                                  g2_reg[7] ^ g2_reg[8] ^ g2_reg[9]};

   genvar gi;
   generate
      for (gi = 0; gi < 10; gi++) begin : g_tap
         assign sel_a[gi] = (taps[7:4] == 4'(gi + 1)) & g2_reg[gi];
         assign sel_b[gi] = (taps[3:0] == 4'(gi + 1)) & g2_reg[gi];
      end
   endgenerate

   assign chip = g1_reg[9] ^ (|sel_a) ^ (|sel_b);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         g1_reg <= '1;
         g2_reg <= '1;
      end else if (load) begin
         g1_reg <= '1;
         g2_reg <= '1;
      end else if (step) begin
         g1_reg <= g1_next;
         g2_reg <= g2_next;
      end
   end
endmodule

// File: rtl/ca_code_acq.sv
// Serial code-phase search: one full-period dwell per candidate phase, one
// discarded sample between dwells to slip the replica by a chip.
module ca_code_acq
   import gnss_ca_pkg::*;
#(
   parameter int CODE_LEN   = CA_LEN,
   parameter int MAX_PHASES = 1023,
   parameter int THRESH     = 700,
   parameter int ACC_W      = 11,
   parameter int PHASE_W    = 10
) (
   input  logic         clk,
   input  logic         rst,
   ca_code_acq_if.slave bus
);
   localparam int CNT_W = $clog2(CODE_LEN + 1);

   acq_state_t              state_reg, state_next;
   logic [5:0]              prn_reg;
   logic signed [ACC_W-1:0] acc_reg, acc_inc, best_corr_reg;
   logic [CNT_W-1:0]        chip_cnt_reg;
   logic [PHASE_W-1:0]      phase_reg, best_phase_reg;
   logic                    lock_reg, err_reg;
   logic                    chip, code_load, code_step;
   logic [ACC_W:0]          acc_mag, best_mag;
   logic                    last_chip, last_phase, hit, better;

   ca_code_step u_step (
      .clk  (clk),
      .rst  (rst),
      .load (code_load),
      .step (code_step),
      .prn  (prn_reg),
      .chip (chip)
   );

   assign acc_inc = (bus.sample_in == chip) ? acc_reg + ACC_W'(1) : acc_reg - ACC_W'(1);

   // magnitudes carry one extra bit so -2^(ACC_W-1) cannot wrap
   assign acc_mag  = acc_inc[ACC_W-1] ? ({1'b0, ~acc_inc} + 1'b1) : {1'b0, acc_inc};
   assign best_mag = best_corr_reg[ACC_W-1] ? ({1'b0, ~best_corr_reg} + 1'b1)
                                            : {1'b0, best_corr_reg};

   assign last_chip  = (chip_cnt_reg == CNT_W'(CODE_LEN - 1));
   assign last_phase = (phase_reg == PHASE_W'(MAX_PHASES - 1));
   assign hit        = (acc_mag >= (ACC_W + 1)'(THRESH));
   assign better     = (acc_mag > best_mag);

   always_comb begin
      state_next = state_reg;
      code_load  = 1'b0;
      code_step  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) state_next = prn_ok(bus.prn_select) ? LOAD : DONE;
         end
         LOAD: begin
            code_load  = 1'b1;
            state_next = DWELL;
         end
         DWELL: begin
            if (bus.sample_valid) begin
               code_step = 1'b1;
               if (last_chip) state_next = (hit || last_phase) ? DONE : SLIP;
            end
         end
         SLIP: begin
            if (bus.sample_valid) state_next = DWELL;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prn_reg        <= '0;
         acc_reg        <= '0;
         chip_cnt_reg   <= '0;
         phase_reg      <= '0;
         best_corr_reg  <= '0;
         best_phase_reg <= '0;
         lock_reg       <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  prn_reg        <= bus.prn_select;
                  err_reg        <= !prn_ok(bus.prn_select);
                  lock_reg       <= 1'b0;
                  best_corr_reg  <= '0;
                  best_phase_reg <= '0;
               end
            end
            LOAD: begin
               acc_reg        <= '0;
               chip_cnt_reg   <= '0;
               phase_reg      <= '0;
               best_corr_reg  <= '0;
               best_phase_reg <= '0;
            end
            DWELL: begin
               if (bus.sample_valid) begin
                  acc_reg      <= acc_inc;
                  chip_cnt_reg <= chip_cnt_reg + CNT_W'(1);
                  if (last_chip) begin
                     // strict compare keeps the earliest phase on ties
                     if (better) begin
                        best_corr_reg  <= acc_inc;
                        best_phase_reg <= phase_reg;
                     end
                     lock_reg <= hit;
                  end
               end
            end
            SLIP: begin
               if (bus.sample_valid) begin
                  phase_reg    <= phase_reg + PHASE_W'(1);
                  acc_reg      <= '0;
                  chip_cnt_reg <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy       = (state_reg == LOAD) || (state_reg == DWELL) || (state_reg == SLIP);
   assign bus.done       = (state_reg == DONE);
   assign bus.lock       = lock_reg;
   assign bus.err        = err_reg;
   assign bus.best_phase = best_phase_reg;
   assign bus.best_corr  = best_corr_reg;
endmodule
